// File: rtl/ad_dly_tap_train.sv
// ad_dly_tap_train: sweeps IDELAY taps 0..31 through the VAR_LOAD port, scores each tap from
// the sample checker, centres the widest passing window. `TRAIN_DBG_EN adds the pass_map port.
module ad_dly_tap_train #(
  parameter int SETTLE_CYC  = 16,
  parameter int SAMPLE_NUM  = 64,
  parameter int SAMPLE_TO   = 4096,
  parameter int MIN_EYE     = 4,
  parameter int DEFAULT_TAP = 10
) (
  input  logic        dly_clk,
  input  logic        rst_in,
  input  logic        dly_rdy,
  input  logic        re_sync_in,
  input  logic        sample_vld,
  input  logic        sample_ok,
  input  logic [4:0]  tap_in,
`ifdef TRAIN_DBG_EN
  output logic [31:0] pass_map,
`endif
  output logic [4:0]  delay_tap,
  output logic        load_en,
  output logic        train_busy,
  output logic        train_done,
  output logic        train_err,
  output logic [4:0]  best_tap
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_WAIT_RDY = 4'd1,
    S_LOAD     = 4'd2,
    S_SETTLE   = 4'd3,
    S_SAMPLE   = 4'd4,
    S_EVAL     = 4'd5,
    S_CENTER   = 4'd6,
    S_CSETTLE  = 4'd7,
    S_DONE     = 4'd8,
    S_ERR      = 4'd9
  } state_t;

  localparam int SCW = $clog2(SETTLE_CYC + 1);
  localparam int VCW = $clog2(SAMPLE_NUM + 1);
  localparam int TCW = $clog2(SAMPLE_TO + 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYC - 1);
  localparam logic [SCW-1:0] SCNT_ONE    = SCW'(1);
  localparam logic [VCW-1:0] VLD_LAST    = VCW'(SAMPLE_NUM - 1);
  localparam logic [VCW-1:0] VCNT_ONE    = VCW'(1);
  localparam logic [TCW-1:0] TO_LAST     = TCW'(SAMPLE_TO - 1);
  localparam logic [TCW-1:0] TCNT_ONE    = TCW'(1);
  localparam logic [5:0]     MIN_LEN     = 6'(MIN_EYE);
  localparam logic [4:0]     DEF_TAP     = 5'(DEFAULT_TAP);
  localparam logic [4:0]     LAST_TAP    = 5'd31;

  state_t         state_q, state_d;
  logic           re_meta_q, re_meta_d, re_prev_q, re_prev_d;
  logic [4:0]     tap_q, tap_d;
  logic [SCW-1:0] cnt_q, cnt_d;
  logic [VCW-1:0] vld_cnt_q, vld_cnt_d;
  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  logic           tap_pass_q, tap_pass_d;
  logic [4:0]     run_start_q, run_start_d;
  logic [5:0]     run_len_q, run_len_d;
  logic [4:0]     best_start_q, best_start_d, best_end_q, best_end_d;
  logic [5:0]     best_len_q, best_len_d;
  logic           eye_err_q, eye_err_d;
  logic [4:0]     delay_tap_q, delay_tap_d, best_tap_q, best_tap_d;
  logic           load_en_q, load_en_d, train_busy_q, train_busy_d;
  logic           train_done_q, train_done_d, train_err_q, train_err_d;
`ifdef TRAIN_DBG_EN
  logic [31:0]    pass_map_q, pass_map_d;
`endif

  logic           start_s, rdy_lost_s, abort_s;
  logic [4:0]     cur_start_s, half_s, center_s;
  logic [5:0]     cur_len_s;

  function automatic logic is_busy(input state_t s);
    case (s)
      S_IDLE, S_DONE, S_ERR: is_busy = 1'b0;
      default:               is_busy = 1'b1;
    endcase
  endfunction

  assign start_s     = re_meta_q & ~re_prev_q;
  assign rdy_lost_s  = is_busy(state_q) & ~dly_rdy & (state_q != S_WAIT_RDY);
  assign abort_s     = start_s | rdy_lost_s;
  // best_end - best_start is best_len - 1, so the centre offset always fits in 5 bits
  assign half_s      = (best_end_q - best_start_q) >> 1;
  assign center_s    = best_start_q + half_s;
  assign cur_start_s = (run_len_q == 6'd0) ? tap_q : run_start_q;
  assign cur_len_s   = run_len_q + 6'd1;

  // next-state logic; a new start outranks loss of dly_rdy
  always_comb begin
    state_d = state_q;
    if (start_s) begin
      state_d = S_WAIT_RDY;
    end else if (rdy_lost_s) begin
      state_d = S_WAIT_RDY;
    end else begin
      case (state_q)
        S_IDLE:     state_d = S_IDLE;
        S_WAIT_RDY: state_d = dly_rdy ? S_LOAD : S_WAIT_RDY;
        S_LOAD:     state_d = S_SETTLE;
        S_SETTLE:   state_d = (cnt_q == SETTLE_LAST) ? S_SAMPLE : S_SETTLE;
        S_SAMPLE: begin
          if (sample_vld && (!sample_ok || (vld_cnt_q == VLD_LAST))) state_d = S_EVAL;
          else if (to_cnt_q == TO_LAST)                              state_d = S_ERR;
          else                                                       state_d = S_SAMPLE;
        end
        S_EVAL:     state_d = (tap_q == LAST_TAP) ? S_CENTER : S_LOAD;
        S_CENTER:   state_d = S_CSETTLE;
        S_CSETTLE: begin
          if (cnt_q != SETTLE_LAST)                       state_d = S_CSETTLE;
          else if (eye_err_q || (tap_in != delay_tap_q))  state_d = S_ERR;
          else                                            state_d = S_DONE;
        end
        S_DONE:     state_d = S_DONE;
        S_ERR:      state_d = S_ERR;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // sweep counters, per-tap scoring and window tracking
  always_comb begin
    re_meta_d    = re_sync_in;
    re_prev_d    = re_meta_q;
    tap_d        = tap_q;
    cnt_d        = cnt_q;
    vld_cnt_d    = vld_cnt_q;
    to_cnt_d     = to_cnt_q;
    tap_pass_d   = tap_pass_q;
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_end_d   = best_end_q;
    best_len_d   = best_len_q;
    eye_err_d    = eye_err_q;
`ifdef TRAIN_DBG_EN
    pass_map_d   = pass_map_q;
`endif
    if (state_d == S_WAIT_RDY) begin
      tap_d        = 5'd0;
      cnt_d        = {SCW{1'b0}};
      vld_cnt_d    = {VCW{1'b0}};
      to_cnt_d     = {TCW{1'b0}};
      tap_pass_d   = 1'b0;
      run_start_d  = 5'd0;
      run_len_d    = 6'd0;
      best_start_d = 5'd0;
      best_end_d   = 5'd0;
      best_len_d   = 6'd0;
      eye_err_d    = 1'b0;
`ifdef TRAIN_DBG_EN
      pass_map_d   = 32'd0;
`endif
    end else begin
      case (state_q)
        S_LOAD:    cnt_d = {SCW{1'b0}};
        S_SETTLE: begin
          cnt_d     = cnt_q + SCNT_ONE;
          vld_cnt_d = {VCW{1'b0}};
          to_cnt_d  = {TCW{1'b0}};
        end
        S_SAMPLE: begin
          to_cnt_d = to_cnt_q + TCNT_ONE;
          if (sample_vld) begin
            if (!sample_ok)                 tap_pass_d = 1'b0;
            else if (vld_cnt_q == VLD_LAST) tap_pass_d = 1'b1;
            else                            vld_cnt_d  = vld_cnt_q + VCNT_ONE;
          end else begin
            vld_cnt_d = vld_cnt_q;
          end
        end
        S_EVAL: begin
          // strict > keeps the earliest of equally wide windows
          if (tap_pass_q) begin
            run_start_d = cur_start_s;
            run_len_d   = cur_len_s;
            if (cur_len_s > best_len_q) begin
              best_start_d = cur_start_s;
              best_end_d   = tap_q;
              best_len_d   = cur_len_s;
            end else begin
              best_len_d   = best_len_q;
            end
          end else begin
            run_len_d = 6'd0;
          end
          tap_d = (tap_q != LAST_TAP) ? (tap_q + 5'd1) : tap_q;
`ifdef TRAIN_DBG_EN
          pass_map_d[tap_q] = tap_pass_q;
`endif
        end
        S_CENTER: begin
          eye_err_d = (best_len_q < MIN_LEN);
          cnt_d     = {SCW{1'b0}};
        end
        S_CSETTLE: cnt_d = cnt_q + SCNT_ONE;
        default:   cnt_d = cnt_q;
      endcase
    end
  end

  // registered outputs; aborts never emit a load pulse
  always_comb begin
    delay_tap_d  = delay_tap_q;
    load_en_d    = 1'b0;
    best_tap_d   = best_tap_q;
    train_busy_d = is_busy(state_d);
    train_done_d = (state_d == S_DONE) || (state_d == S_ERR);
    train_err_d  = (state_d == S_ERR);
    if (!abort_s) begin
      case (state_q)
        S_LOAD: begin
          load_en_d   = 1'b1;
          delay_tap_d = tap_q;
        end
        S_SAMPLE: begin
          if (state_d == S_ERR) begin
            load_en_d   = 1'b1;
            delay_tap_d = DEF_TAP;
            best_tap_d  = DEF_TAP;
          end else begin
            load_en_d   = 1'b0;
          end
        end
        S_CENTER: begin
          load_en_d   = 1'b1;
          delay_tap_d = (best_len_q >= MIN_LEN) ? center_s : DEF_TAP;
        end
        S_CSETTLE: begin
          if (state_d == S_DONE)     best_tap_d = delay_tap_q;
          else if (state_d == S_ERR) best_tap_d = DEF_TAP;
          else                       best_tap_d = best_tap_q;
        end
        default: load_en_d = 1'b0;
      endcase
    end else begin
      load_en_d = 1'b0;
    end
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge dly_clk) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      re_meta_q    <= 1'b0;
      re_prev_q    <= 1'b0;
      tap_q        <= 5'd0;
      cnt_q        <= {SCW{1'b0}};
      vld_cnt_q    <= {VCW{1'b0}};
      to_cnt_q     <= {TCW{1'b0}};
      tap_pass_q   <= 1'b0;
      run_start_q  <= 5'd0;
      run_len_q    <= 6'd0;
      best_start_q <= 5'd0;
      best_end_q   <= 5'd0;
      best_len_q   <= 6'd0;
      eye_err_q    <= 1'b0;
      delay_tap_q  <= 5'd0;
      load_en_q    <= 1'b0;
      train_busy_q <= 1'b0;
      train_done_q <= 1'b0;
      train_err_q  <= 1'b0;
      best_tap_q   <= 5'd0;
`ifdef TRAIN_DBG_EN
      pass_map_q   <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      re_meta_q    <= re_meta_d;
      re_prev_q    <= re_prev_d;
      tap_q        <= tap_d;
      cnt_q        <= cnt_d;
      vld_cnt_q    <= vld_cnt_d;
      to_cnt_q     <= to_cnt_d;
      tap_pass_q   <= tap_pass_d;
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_end_q   <= best_end_d;
      best_len_q   <= best_len_d;
      eye_err_q    <= eye_err_d;
      delay_tap_q  <= delay_tap_d;
      load_en_q    <= load_en_d;
      train_busy_q <= train_busy_d;
      train_done_q <= train_done_d;
      train_err_q  <= train_err_d;
      best_tap_q   <= best_tap_d;
`ifdef TRAIN_DBG_EN
      pass_map_q   <= pass_map_d;
`endif
    end
  end

  assign delay_tap  = delay_tap_q;
  assign load_en    = load_en_q;
  assign train_busy = train_busy_q;
  assign train_done = train_done_q;
  assign train_err  = train_err_q;
  assign best_tap   = best_tap_q;
`ifdef TRAIN_DBG_EN
  assign pass_map   = pass_map_q;
`endif

endmodule

// File: tb/tb_ad_dly_tap_train.sv
// Bench for ad_dly_tap_train: a sample-checker model scores taps from a pass pattern and a
// window-search reference predicts the trained tap.
`timescale 1ns/100ps
module tb_ad_dly_tap_train;

  logic        dly_clk = 1'b0;
  logic        rst_in, dly_rdy, re_sync_in, sample_vld, sample_ok;
  logic [4:0]  tap_in, delay_tap, best_tap;
  logic        load_en, train_busy, train_done, train_err;
`ifdef TRAIN_DBG_EN
  logic [31:0] pass_map;
`endif

  int          total = 0;
  int          bad   = 0;
  logic [31:0] pass_pat  = 32'h0;
  bit          vld_en    = 1'b1;
  bit          tap_stuck = 1'b0;
  logic [4:0]  loads[$];

  initial forever #2.5 dly_clk = ~dly_clk;

  ad_dly_tap_train dut (
    .dly_clk    (dly_clk),
    .rst_in     (rst_in),
    .dly_rdy    (dly_rdy),
    .re_sync_in (re_sync_in),
    .sample_vld (sample_vld),
    .sample_ok  (sample_ok),
    .tap_in     (tap_in),
`ifdef TRAIN_DBG_EN
    .pass_map   (pass_map),
`endif
    .delay_tap  (delay_tap),
    .load_en    (load_en),
    .train_busy (train_busy),
    .train_done (train_done),
    .train_err  (train_err),
    .best_tap   (best_tap)
  );

  // sample checker and IDELAY readback model: failing taps give random ok bits
  initial begin
    sample_vld = 1'b0;
    sample_ok  = 1'b0;
    tap_in     = 5'd0;
    forever begin
      @(negedge dly_clk);
      tap_in     = tap_stuck ? 5'd0 : delay_tap;
      sample_vld = vld_en && ($urandom_range(3) != 0);
      sample_ok  = pass_pat[delay_tap] ? 1'b1 : ($urandom_range(1) == 0);
    end
  end

  initial forever begin
    @(negedge dly_clk);
    if (load_en) loads.push_back(delay_tap);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge dly_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // widest all-pass window over every (start,end) pair; earliest start wins ties
  function automatic void ref_train(input logic [31:0] p, output logic [4:0] bt, output logic er);
    int bl = 0;
    int bs = 0;
    bit all;
    for (int s = 0; s < 32; s++) begin
      for (int e = s; e < 32; e++) begin
        all = 1'b1;
        for (int t = s; t <= e; t++) if (!p[t]) all = 1'b0;
        if (all && ((e - s + 1) > bl)) begin
          bl = e - s + 1;
          bs = s;
        end
      end
    end
    if (bl >= 4) begin
      bt = 5'(bs + (bl - 1) / 2);
      er = 1'b0;
    end else begin
      bt = 5'd10;
      er = 1'b1;
    end
  endfunction

  task automatic pulse_start();
    re_sync_in = 1'b1;
    tick(3);
    re_sync_in = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (!train_done && cycles < budget) begin
      tick(1);
      cycles++;
    end
    chk({tag, "_done_seen"}, {31'd0, train_done}, 32'd1);
  endtask

  task automatic wait_load(input string tag, input logic [4:0] t, input int budget);
    int c = 0;
    while (!(load_en && delay_tap == t) && c < budget) begin
      tick(1);
      c++;
    end
    chk({tag, "_load_seen"}, {31'd0, load_en && (delay_tap == t)}, 32'd1);
  endtask

  task automatic wait_new_load(input string tag, input int n, input int budget);
    int c = 0;
    while (loads.size() <= n && c < budget) begin
      tick(1);
      c++;
    end
    chk({tag, "_first_load"}, (loads.size() > n) ? {27'd0, loads[n]} : 32'hdead, 32'd0);
  endtask

  // checks outcome and the full load sequence starting at queue index base
  task automatic check_result(input string tag, input logic [31:0] pat, input bit stuck, input int base);
    logic [4:0] bt;
    logic       er;
    bit         order_ok;
    ref_train(pat, bt, er);
    chk({tag, "_done"}, {31'd0, train_done}, 32'd1);
    chk({tag, "_busy"}, {31'd0, train_busy}, 32'd0);
    chk({tag, "_err"},  {31'd0, train_err},  {31'd0, er | stuck});
    chk({tag, "_delay_tap"}, {27'd0, delay_tap}, {27'd0, bt});
    if (!stuck) chk({tag, "_best_tap"}, {27'd0, best_tap}, {27'd0, bt});
    order_ok = (loads.size() == base + 33);
    for (int i = 0; i < 32; i++) if (order_ok && loads[base + i] != 5'(i)) order_ok = 1'b0;
    chk({tag, "_sweep_order"}, {31'd0, order_ok}, 32'd1);
    chk({tag, "_final_load"}, order_ok ? {27'd0, loads[base + 32]} : 32'hdead, {27'd0, bt});
`ifdef TRAIN_DBG_EN
    chk({tag, "_pass_map"}, pass_map, pat);
`endif
  endtask

  task automatic run_full(input string tag, input logic [31:0] pat, input bit stuck);
    int cyc;
    pass_pat  = pat;
    tap_stuck = stuck;
    loads.delete();
    pulse_start();
    chk({tag, "_busy_start"}, {31'd0, train_busy}, 32'd1);
    chk({tag, "_done_clear"}, {31'd0, train_done}, 32'd0);
    wait_done(tag, 20000, cyc);
    check_result(tag, pat, stuck, 0);
    tap_stuck = 1'b0;
  endtask

  initial begin
    int cyc;
    int n;
    logic [31:0] pat;
    rst_in     = 1'b1;
    dly_rdy    = 1'b1;
    re_sync_in = 1'b0;
    tick(4);
    rst_in = 1'b0;
    tick(2);
    chk("rst_delay_tap", {27'd0, delay_tap}, 32'd0);
    chk("rst_load_en",   {31'd0, load_en},   32'd0);
    chk("rst_busy",      {31'd0, train_busy}, 32'd0);
    chk("rst_done",      {31'd0, train_done}, 32'd0);
    chk("rst_err",       {31'd0, train_err},  32'd0);
    chk("rst_best_tap",  {27'd0, best_tap},   32'd0);

    run_full("eye_8_19", 32'h000F_FF00, 1'b0);
    run_full("two_windows", 32'h03F0_00FC, 1'b0);
    run_full("window_28_31", 32'hF000_0000, 1'b0);
    run_full("narrow_eye", 32'h0000_00E0, 1'b0);

    // sample stream absent at tap 0: timeout, default tap loaded
    vld_en = 1'b0;
    loads.delete();
    pulse_start();
    wait_done("timeout", 6000, cyc);
    chk("timeout_window", {31'd0, (cyc >= 4090) && (cyc <= 4130)}, 32'd1);
    chk("timeout_err", {31'd0, train_err}, 32'd1);
    chk("timeout_delay_tap", {27'd0, delay_tap}, 32'd10);
    chk("timeout_best_tap", {27'd0, best_tap}, 32'd10);
    chk("timeout_loads", {26'd0, loads.size() == 2, (loads.size() == 2) ? loads[1] : 5'd0}, 32'h2a);
    vld_en = 1'b1;

    // restart request in the middle of the sweep
    pass_pat = 32'h000F_FF00;
    loads.delete();
    pulse_start();
    wait_load("restart", 5'd17, 10000);
    n = loads.size();
    pulse_start();
    chk("restart_done_low", {31'd0, train_done}, 32'd0);
    wait_new_load("restart", n, 100);
    chk("restart_busy", {31'd0, train_busy}, 32'd1);
    wait_done("restart", 20000, cyc);
    check_result("restart", 32'h000F_FF00, 1'b0, n);

    // dly_rdy lost mid-sweep
    loads.delete();
    pulse_start();
    wait_load("rdy_loss", 5'd9, 10000);
    tick(1);
    n = loads.size();
    dly_rdy = 1'b0;
    tick(6);
    chk("rdy_loss_busy", {31'd0, train_busy}, 32'd1);
    chk("rdy_loss_no_load", loads.size(), n);
    dly_rdy = 1'b1;
    wait_new_load("rdy_loss", n, 100);
    wait_done("rdy_loss", 20000, cyc);
    check_result("rdy_loss", 32'h000F_FF00, 1'b0, n);

    run_full("stuck_readback", 32'h000F_FF00, 1'b1);

    // reset in the middle of a sweep
    loads.delete();
    pulse_start();
    wait_load("mid_rst", 5'd5, 10000);
    rst_in = 1'b1;
    tick(1);
    rst_in = 1'b0;
    n = loads.size();
    chk("mid_rst_outs", {delay_tap, load_en, train_busy, train_done, train_err, best_tap}, 32'd0);
    tick(40);
    chk("mid_rst_idle", {loads.size() == n, train_busy, train_done}, 32'h4);

    for (int k = 0; k < 4; k++) begin
      int s = $urandom_range(31);
      int w = $urandom_range(12, 1);
      pat = $urandom() & $urandom() & $urandom();
      for (int t = s; t < s + w && t < 32; t++) pat[t] = 1'b1;
      run_full($sformatf("rand%0d", k), pat, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
